// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor definitions.
//   bp_fsm_e  : state encoding of the prediction-table flush controller
//   bp_pred_e : 2-bit saturating-counter prediction encodings
package riscv_bp_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StClear = 2'b01,
        StIdle  = 2'b10
    } bp_fsm_e;

    // Gray-ordered so a single bit flip moves one step of confidence.
    typedef enum logic [1:0] {
        PredStrongNt = 2'b00,
        PredWeakNt   = 2'b01,
        PredWeakT    = 2'b11,
        PredStrongT  = 2'b10
    } bp_pred_e;

endpackage

// File: rtl/riscv_bp_flush_ctrl.sv
// Branch-prediction table flush controller.
// Sweeps every table entry back to INIT_PREDICTION after reset (optional) and on
// request, and otherwise forwards branch-unit updates to the table RAM.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_req_i / flush_ack_o clear request, one-cycle ack when the clear completes
//   busy_o                    clear in progress, predictions not valid
//   upd_we_i/_waddr_i/_wdata_i  branch-unit update port
//   upd_drop_o                update discarded this cycle (table busy clearing)
//   ram_we_o/_waddr_o/_wdata_o  table RAM write port
//   ram_rdata_i               registered table RAM read data
//   predict_o                 prediction to fetch
module riscv_bp_flush_ctrl
    import riscv_bp_pkg::*;
#(
    parameter int unsigned BP_GLOBAL_BITS  = 2,
    parameter int unsigned BP_LOCAL_BITS   = 10,
    parameter logic [1:0]  INIT_PREDICTION = PredWeakNt,
    parameter bit          CLEAR_ON_RESET  = 1'b1,
    localparam int unsigned ADR_BITS       = BP_GLOBAL_BITS + BP_LOCAL_BITS,
    localparam int unsigned DEPTH          = 1 << ADR_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    input  logic                upd_we_i,
    input  logic [ADR_BITS-1:0] upd_waddr_i,
    input  logic [1:0]          upd_wdata_i,
    output logic                upd_drop_o,
    output logic                ram_we_o,
    output logic [ADR_BITS-1:0] ram_waddr_o,
    output logic [1:0]          ram_wdata_o,
    input  logic [1:0]          ram_rdata_i,
    output logic [1:0]          predict_o
);

    localparam logic [ADR_BITS-1:0] CntLast = ADR_BITS'(DEPTH - 1);

    bp_fsm_e             state_q;
    logic [ADR_BITS-1:0] cnt_q;
    logic                pend_q;   // a flush request awaits its ack

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flush_ack_o <= 1'b0;
            busy_o      <= CLEAR_ON_RESET;
        end else begin
            flush_ack_o <= 1'b0;
            case (state_q)
                StInit: begin
                    // A request arriving before the first sweep starts still needs a clear.
                    pend_q <= pend_q | flush_req_i;
                    if (CLEAR_ON_RESET || flush_req_i) begin
                        state_q <= StClear;
                        busy_o  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                end
                StClear: begin
                    cnt_q  <= cnt_q + 1'b1;
                    busy_o <= 1'b1;
                    if (cnt_q == CntLast) begin
                        // busy_o stays high one more cycle to cover the RAM read latency.
                        state_q     <= StIdle;
                        flush_ack_o <= pend_q | flush_req_i;
                        pend_q      <= 1'b0;
                    end else begin
                        pend_q <= pend_q | flush_req_i;
                    end
                end
                StIdle: begin
                    if (flush_req_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        pend_q  <= 1'b1;
                        busy_o  <= 1'b1;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    always_comb begin
        ram_we_o    = 1'b0;
        ram_waddr_o = cnt_q;
        ram_wdata_o = INIT_PREDICTION;
        upd_drop_o  = 1'b0;
        case (state_q)
            StClear: begin
                ram_we_o   = 1'b1;
                upd_drop_o = upd_we_i;
            end
            StIdle: begin
                ram_we_o    = upd_we_i;
                ram_waddr_o = upd_waddr_i;
                ram_wdata_o = upd_wdata_i;
            end
            default: begin
                upd_drop_o = upd_we_i;
            end
        endcase
    end

    assign predict_o = busy_o ? INIT_PREDICTION : ram_rdata_i;

endmodule

// File: doc/riscv_bp_flush_ctrl.md
RISCV_BP_FLUSH_CTRL -- requirements
Module: riscv_bp_flush_ctrl

Interface
REQ-001 SHALL have parameter BP_GLOBAL_BITS, default 2, global history bits of the table address.
REQ-002 SHALL have parameter BP_LOCAL_BITS, default 10, PC-derived bits of the table address.
REQ-003 SHALL have parameter INIT_PREDICTION, 2 bits, default 2'b01 (weakly not-taken), the value written by every clear.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, the table is cleared after every reset.
REQ-005 SHALL derive the localparams ADR_BITS = BP_GLOBAL_BITS+BP_LOCAL_BITS and DEPTH = 1<<ADR_BITS.
REQ-006 SHALL use reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-007 Ports, in order:
 clk_i  in  1  clock
 rst_ni  in  1  async active-low reset
 flush_req_i  in  1  single-cycle request to clear the whole table (fence.i/context switch)
 flush_ack_o  out  1  single-cycle pulse when a requested clear completes
 busy_o  out  1  clear in progress; predictions not valid
 upd_we_i  in  1  branch-unit update strobe
 upd_waddr_i  in  ADR_BITS  update address {history, pc bits}
 upd_wdata_i  in  2  new 2-bit counter value
 upd_drop_o  out  1  pulse: the update in this cycle was discarded
 ram_we_o  out  1  table RAM write enable
 ram_waddr_o  out  ADR_BITS  table RAM write address
 ram_wdata_o  out  2  table RAM write data
 ram_rdata_i  in  2  registered table RAM read data
 predict_o  out  2  prediction to fetch

Function
REQ-008 SHALL implement the FSM states INIT, CLEAR and IDLE.
REQ-009 SHALL leave INIT on the first clock edge after reset release: to CLEAR if CLEAR_ON_RESET=1, else to IDLE.
REQ-010 In CLEAR, SHALL drive ram_we_o=1, ram_waddr_o=cnt and ram_wdata_o=INIT_PREDICTION.
REQ-011 In CLEAR, SHALL increment the ADR_BITS-wide counter cnt by 1 per cycle.
REQ-012 SHALL leave CLEAR for IDLE after the cycle with cnt==DEPTH-1, so that exactly DEPTH writes occur (addresses 0..DEPTH-1) and cnt wraps to 0.
REQ-013 In IDLE, SHALL pass the update port through combinationally: ram_we_o=upd_we_i, ram_waddr_o=upd_waddr_i, ram_wdata_o=upd_wdata_i.
REQ-014 In INIT or CLEAR, SHALL discard any upd_we_i and assert upd_drop_o in the same cycle; no update is buffered.
REQ-015 When flush_req_i is high in IDLE, SHALL perform the same-cycle update, if any, and enter CLEAR next cycle with cnt=0.
REQ-016 When flush_req_i is high in CLEAR or INIT, SHALL merge it into the ongoing or pending clear without restarting cnt, and set the pending-ack flag.
REQ-017 SHALL pulse flush_ack_o for exactly one cycle in the first IDLE cycle after a clear, and only if a flush request was accepted since the last ack; a reset-only clear gives no ack.
REQ-018 SHALL assert busy_o in INIT (when CLEAR_ON_RESET=1), in CLEAR, and for one cycle after CLEAR exits, covering the RAM read latency.
REQ-019 SHALL drive predict_o=INIT_PREDICTION while busy_o=1, and predict_o=ram_rdata_i otherwise.
REQ-020 In INIT, SHALL drive ram_we_o=0.

Reset
REQ-021 On reset, SHALL set: state=INIT, cnt=0, pending-ack=0, flush_ack_o=0, busy_o=CLEAR_ON_RESET, ram_we_o=0, upd_drop_o=0.
REQ-022 SHALL abort a clear in progress when reset is asserted, and start a new clear from address 0 when CLEAR_ON_RESET=1; any pending ack is lost.

Structure
REQ-023 SHALL place the FSM state enum and the 2-bit prediction encodings (00 strong-NT, 01 weak-NT, 11 weak-T, 10 strong-T) in the shared package riscv_bp_pkg.
REQ-024 SHALL have no sub-module; the counter and FSM are inline, and the table RAM (rl_ram_1r1w) is instantiated by the parent.

Verification (BP_GLOBAL_BITS=2, BP_LOCAL_BITS=2, DEPTH=16)
REQ-025 Release reset -> ram_we_o high for exactly 16 cycles with addresses 0..15, data 2'b01; busy_o falls one cycle after the last write; flush_ack_o never pulses.
REQ-026 In IDLE, upd_we_i=1, addr=5, data=2'b11 -> ram_we_o=1, addr 5, data 2'b11 in the same cycle; upd_drop_o=0.
REQ-027 flush_req_i and an update to addr 3 in the same IDLE cycle -> addr 3 written first, then 16 clear writes, then flush_ack_o pulses once.
REQ-028 A second flush_req_i at cnt=7 -> the clear continues 8..15 without restart, with a single ack.
REQ-029 upd_we_i during CLEAR -> upd_drop_o=1 that cycle, no write to upd_waddr_i, and predict_o=2'b01 throughout.
REQ-030 Reset asserted at cnt=9 during a flush clear -> after release, a full 0..15 clear with no flush_ack_o.
